// File: rtl/reconfig_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reconfig_pkg
// Brief    : State encoding and parameter defaults for reconfig_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package reconfig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SEND  = 2'd2,
        ST_GUARD = 2'd3
    } state_t;

    localparam int c_DEF_DATA_WIDTH    = 512;
    localparam int c_DEF_TUSER_WIDTH   = 128;
    localparam int c_DEF_PHV_LEN       = 1024;
    localparam int c_DEF_NUM_STAGES    = 5;
    localparam int c_DEF_CTL_DEPTH     = 16;
    localparam int c_DEF_DRAIN_TIMEOUT = 1024;
    localparam int c_DEF_GUARD_CYCLES  = 20;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctl_beat_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ctl_beat_fifo
// Brief    : Synchronous FIFO with flush, holding one control packet's beats.
// Revision : 1.0 - initial release
// ============================================================================
module ctl_beat_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             axis_clk,
    input  logic             aresetn,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int              c_AW        = $clog2(DEPTH);
    localparam int              c_CW        = $clog2(DEPTH + 1);
    localparam logic [c_AW-1:0] c_LAST_IDX  = c_AW'(DEPTH - 1);
    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_full    = (r_count == c_DEPTH_CNT);
    assign o_empty   = (r_count == '0);
    assign w_do_wr   = i_wr_en & ~o_full;
    assign w_do_rd   = i_rd_en & ~o_empty;
    assign o_rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge axis_clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Flush overrides any same-cycle push or pop.
    always_ff @(posedge axis_clk) begin
        if (!aresetn || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_IDX) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/reconfig_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reconfig_sequencer
// Brief    : Buffers a control packet, drains the PHV pipeline, then injects it.
// Revision : 1.0 - initial release
// ============================================================================
module reconfig_sequencer
    import reconfig_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = c_DEF_DATA_WIDTH,
    parameter int C_S_AXIS_TUSER_WIDTH = c_DEF_TUSER_WIDTH,
    parameter int PHV_LEN              = c_DEF_PHV_LEN,
    parameter int NUM_OF_STAGES        = c_DEF_NUM_STAGES,
    parameter int CTL_DEPTH            = c_DEF_CTL_DEPTH,
    parameter int DRAIN_TIMEOUT        = c_DEF_DRAIN_TIMEOUT,
    parameter int GUARD_CYCLES         = c_DEF_GUARD_CYCLES
) (
    input  logic                                 axis_clk,
    input  logic                                 aresetn,
    input  logic [PHV_LEN-1:0]                   phv_in,
    input  logic                                 phv_in_valid,
    output logic                                 phv_in_ready,
    output logic [PHV_LEN-1:0]                   phv_out,
    output logic                                 phv_out_valid,
    input  logic                                 phv_out_ready,
    input  logic                                 phv_retire,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_s_axis_tkeep,
    input  logic                                 c_s_axis_tvalid,
    input  logic                                 c_s_axis_tlast,
    output logic                                 c_s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]       c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_m_axis_tkeep,
    output logic                                 c_m_axis_tvalid,
    output logic                                 c_m_axis_tlast,
    output logic                                 busy,
    output logic                                 err_timeout,
    output logic                                 err_oversize
);
    localparam int c_KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int c_BEAT_W = C_S_AXIS_DATA_WIDTH + C_S_AXIS_TUSER_WIDTH + c_KEEP_W + 1;
    localparam int c_INFL_W = $clog2(CTL_DEPTH * NUM_OF_STAGES) + 4;
    localparam int c_TMR_W  = $clog2(max_int(DRAIN_TIMEOUT, GUARD_CYCLES) + 1);
    localparam logic [c_TMR_W-1:0] c_DRAIN_LAST = c_TMR_W'(DRAIN_TIMEOUT - 1);
    localparam logic [c_TMR_W-1:0] c_GUARD_LAST = c_TMR_W'(GUARD_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_rst_done;
    logic                  r_pkt_done;
    logic                  r_discard;
    logic [c_INFL_W-1:0]   r_inflight;
    logic [c_TMR_W-1:0]    r_tmr;

    logic                  w_busy;
    logic                  w_gate_open;
    logic                  w_fifo_rd;
    logic                  w_tmr_run;
    logic                  w_beat_acc;
    logic                  w_overflow;
    logic                  w_fifo_wr;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [c_BEAT_W-1:0]   w_fifo_head;
    logic                  w_head_last;
    logic                  w_phv_inc;
    logic                  w_drain_expired;
    logic                  w_timeout_hit;

    assign phv_out         = phv_in;
    assign phv_out_valid   = phv_in_valid & w_gate_open;
    assign phv_in_ready    = phv_out_ready & w_gate_open;
    assign c_s_axis_tready = r_rst_done & (r_state == ST_IDLE) & ~r_pkt_done;
    assign busy            = w_busy;

    assign w_beat_acc      = c_s_axis_tvalid & c_s_axis_tready;
    // Any beat arriving at a full buffer is oversize, even a tlast one;
    // discard mode is only needed when the packet has more beats to come.
    assign w_overflow      = w_beat_acc & ~r_discard & w_fifo_full;
    assign w_fifo_wr       = w_beat_acc & ~r_discard & ~w_fifo_full;
    assign w_head_last     = w_fifo_head[c_BEAT_W-1];
    assign w_phv_inc       = phv_out_valid & phv_out_ready;
    assign w_drain_expired = (r_tmr == c_DRAIN_LAST);
    assign w_timeout_hit   = (r_state == ST_DRAIN) & (r_inflight != '0) & w_drain_expired;

    ctl_beat_fifo #(
        .WIDTH (c_BEAT_W),
        .DEPTH (CTL_DEPTH)
    ) u_ctl_fifo (
        .axis_clk  (axis_clk),
        .aresetn   (aresetn),
        .i_flush   (w_overflow),
        .i_wr_en   (w_fifo_wr),
        .i_wr_data ({c_s_axis_tlast, c_s_axis_tkeep, c_s_axis_tuser, c_s_axis_tdata}),
        .i_rd_en   (w_fifo_rd),
        .o_rd_data (w_fifo_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (r_pkt_done) w_state_next = ST_DRAIN;
            ST_DRAIN: if ((r_inflight == '0) || w_drain_expired) w_state_next = ST_SEND;
            ST_SEND:  if (w_fifo_empty || w_head_last) w_state_next = ST_GUARD;
            ST_GUARD: if (r_tmr == c_GUARD_LAST) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = 1'b1;
        w_gate_open = 1'b0;
        w_fifo_rd   = 1'b0;
        w_tmr_run   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy      = 1'b0;
                w_gate_open = 1'b1;
            end
            ST_DRAIN: w_tmr_run = 1'b1;
            ST_SEND:  w_fifo_rd = ~w_fifo_empty;
            ST_GUARD: w_tmr_run = 1'b1;
            default:  w_busy    = 1'b1;
        endcase
    end

    // One timer serves both DRAIN and GUARD; it restarts on every state change.
    always_ff @(posedge axis_clk) begin
        if (!aresetn || (w_state_next != r_state)) begin
            r_tmr <= '0;
        end else if (w_tmr_run) begin
            r_tmr <= r_tmr + 1'b1;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            r_inflight <= '0;
        end else if (w_phv_inc && !phv_retire) begin
            r_inflight <= r_inflight + 1'b1;
        end else if (!w_phv_inc && phv_retire && (r_inflight != '0)) begin
            r_inflight <= r_inflight - 1'b1;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            r_rst_done   <= 1'b0;
            r_pkt_done   <= 1'b0;
            r_discard    <= 1'b0;
            err_timeout  <= 1'b0;
            err_oversize <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_fifo_wr && c_s_axis_tlast) begin
                r_pkt_done <= 1'b1;
            end else if ((r_state == ST_IDLE) && r_pkt_done) begin
                r_pkt_done <= 1'b0;
            end
            if (w_overflow) begin
                r_discard    <= ~c_s_axis_tlast;
                err_oversize <= 1'b1;
            end else if (w_beat_acc && r_discard && c_s_axis_tlast) begin
                r_discard <= 1'b0;
            end
            if (w_timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn || !w_fifo_rd) begin
            c_m_axis_tdata  <= '0;
            c_m_axis_tuser  <= '0;
            c_m_axis_tkeep  <= '0;
            c_m_axis_tlast  <= 1'b0;
            c_m_axis_tvalid <= 1'b0;
        end else begin
            {c_m_axis_tlast, c_m_axis_tkeep, c_m_axis_tuser, c_m_axis_tdata} <= w_fifo_head;
            c_m_axis_tvalid <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reconfig_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reconfig_sequencer
// Brief    : Randomized scenario bench for reconfig_sequencer against a packet/count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reconfig_sequencer;
    localparam int DW    = 32;
    localparam int UW    = 8;
    localparam int KW    = DW / 8;
    localparam int PW    = 16;
    localparam int DEPTH = 16;
    localparam int TMO   = 16;
    localparam int GUARD = 20;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic          axis_clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [PW-1:0] phv_in = '0;
    logic          phv_in_valid = 1'b0;
    logic          phv_in_ready;
    logic [PW-1:0] phv_out;
    logic          phv_out_valid;
    logic          phv_out_ready = 1'b1;
    logic          phv_retire = 1'b0;
    logic [DW-1:0] c_s_axis_tdata = '0;
    logic [UW-1:0] c_s_axis_tuser = '0;
    logic [KW-1:0] c_s_axis_tkeep = '0;
    logic          c_s_axis_tvalid = 1'b0;
    logic          c_s_axis_tlast = 1'b0;
    logic          c_s_axis_tready;
    logic [DW-1:0] c_m_axis_tdata;
    logic [UW-1:0] c_m_axis_tuser;
    logic [KW-1:0] c_m_axis_tkeep;
    logic          c_m_axis_tvalid;
    logic          c_m_axis_tlast;
    logic          busy;
    logic          err_timeout;
    logic          err_oversize;

    int    n_cmp = 0;
    int    n_fail = 0;
    int    infl_model = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];

    reconfig_sequencer #(
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .PHV_LEN              (PW),
        .NUM_OF_STAGES        (5),
        .CTL_DEPTH            (DEPTH),
        .DRAIN_TIMEOUT        (TMO),
        .GUARD_CYCLES         (GUARD)
    ) dut (
        .axis_clk        (axis_clk),
        .aresetn         (aresetn),
        .phv_in          (phv_in),
        .phv_in_valid    (phv_in_valid),
        .phv_in_ready    (phv_in_ready),
        .phv_out         (phv_out),
        .phv_out_valid   (phv_out_valid),
        .phv_out_ready   (phv_out_ready),
        .phv_retire      (phv_retire),
        .c_s_axis_tdata  (c_s_axis_tdata),
        .c_s_axis_tuser  (c_s_axis_tuser),
        .c_s_axis_tkeep  (c_s_axis_tkeep),
        .c_s_axis_tvalid (c_s_axis_tvalid),
        .c_s_axis_tlast  (c_s_axis_tlast),
        .c_s_axis_tready (c_s_axis_tready),
        .c_m_axis_tdata  (c_m_axis_tdata),
        .c_m_axis_tuser  (c_m_axis_tuser),
        .c_m_axis_tkeep  (c_m_axis_tkeep),
        .c_m_axis_tvalid (c_m_axis_tvalid),
        .c_m_axis_tlast  (c_m_axis_tlast),
        .busy            (busy),
        .err_timeout     (err_timeout),
        .err_oversize    (err_oversize)
    );

    always #5 axis_clk = ~axis_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge axis_clk);
        #2;
    endtask

    // Pipeline occupancy as seen from outside: accepted minus retired, floor 0.
    function automatic void model_step(input bit acc, input bit ret);
        if (acc && ret) infl_model = infl_model;
        else if (acc) infl_model = infl_model + 1;
        else if (ret && infl_model > 0) infl_model = infl_model - 1;
    endfunction

    task automatic push_phvs(input int n);
        bit acc;
        for (int i = 0; i < n; i++) begin
            phv_in = PW'($urandom);
            phv_in_valid = 1'b1;
            #1;
            acc = phv_out_valid && phv_out_ready;
            tick();
            model_step(acc, 1'b0);
        end
        phv_in_valid = 1'b0;
    endtask

    task automatic retire_all();
        while (infl_model > 0) begin
            phv_retire = 1'b1;
            tick();
            model_step(1'b0, 1'b1);
        end
        phv_retire = 1'b0;
    endtask

    task automatic send_pkt(input int n, input bit record, output bit tmo);
        beat_t b;
        int    w;
        tmo = 1'b0;
        for (int i = 0; i < n; i++) begin
            b.d = $urandom;
            b.u = UW'($urandom);
            b.k = KW'($urandom);
            b.l = (i == n - 1);
            {c_s_axis_tdata, c_s_axis_tuser, c_s_axis_tkeep, c_s_axis_tlast} = b;
            c_s_axis_tvalid = 1'b1;
            #1;
            w = 0;
            while (!c_s_axis_tready && w < 50) begin
                tick();
                w++;
            end
            if (!c_s_axis_tready) tmo = 1'b1;
            tick();
            if (record) exp_q.push_back(b);
        end
        c_s_axis_tvalid = 1'b0;
        c_s_axis_tlast  = 1'b0;
    endtask

    task automatic capture_pkt(input int budget, output bit tmo, output int waited);
        obs_q.delete();
        tmo = 1'b0;
        waited = 0;
        while (!c_m_axis_tvalid && waited < budget) begin
            tick();
            waited++;
        end
        if (!c_m_axis_tvalid) tmo = 1'b1;
        while (c_m_axis_tvalid && obs_q.size() < 64) begin
            obs_q.push_back({c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tlast});
            tick();
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) tick();
        n_cmp++; if ({c_s_axis_tready, c_m_axis_tvalid, busy, err_timeout, err_oversize} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b required 00000", {c_s_axis_tready, c_m_axis_tvalid, busy, err_timeout, err_oversize});
        end
        n_cmp++; if ({c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tlast} !== '0) begin
            n_fail++; $display("FAIL reset_cm_data: got %h required 0", c_m_axis_tdata);
        end
        aresetn = 1'b1;
        #1;
        n_cmp++; if (c_s_axis_tready !== 1'b0) begin
            n_fail++; $display("FAIL reset_tready_early: got %b required 0", c_s_axis_tready);
        end
        tick();
        n_cmp++; if (c_s_axis_tready !== 1'b1) begin
            n_fail++; $display("FAIL reset_tready_after: got %b required 1", c_s_axis_tready);
        end
    endtask

    task automatic test_passthrough();
        int  hs = 0;
        int  bad = 0;
        bit  rdy;
        for (int i = 0; i < 18; i++) begin
            rdy = (i < 10) ? 1'b1 : 1'($urandom_range(0, 1));
            phv_in = PW'($urandom);
            phv_in_valid = 1'b1;
            phv_out_ready = rdy;
            #1;
            if (phv_out !== phv_in || phv_out_valid !== 1'b1 || phv_in_ready !== rdy || busy !== 1'b0) bad++;
            if (phv_out_valid && phv_out_ready) hs++;
            tick();
            model_step(phv_out_valid && phv_out_ready, 1'b0);
            if (i == 9) begin
                n_cmp++; if (hs !== 10) begin
                    n_fail++; $display("FAIL pass_handshakes: got %0d required 10", hs);
                end
            end
        end
        phv_in_valid = 1'b0;
        phv_out_ready = 1'b1;
        n_cmp++; if (bad !== 0) begin
            n_fail++; $display("FAIL pass_gate: got %0d bad cycles required 0", bad);
        end
        retire_all();
    endtask

    task automatic test_drain();
        bit tmo;
        int waited;
        int early = 0;
        int n;
        push_phvs(3);
        send_pkt(2, 1'b1, tmo);
        n_cmp++; if (tmo !== 1'b0) begin
            n_fail++; $display("FAIL drain_accept: got timeout required accepted");
        end
        n_cmp++; if (c_s_axis_tready !== 1'b0) begin
            n_fail++; $display("FAIL drain_tready_drop: got %b required 0", c_s_axis_tready);
        end
        tick();
        phv_in_valid = 1'b1;
        #1;
        n_cmp++; if ({phv_in_ready, phv_out_valid, busy} !== 3'b001) begin
            n_fail++; $display("FAIL drain_gate_closed: got %b required 001", {phv_in_ready, phv_out_valid, busy});
        end
        phv_in_valid = 1'b0;
        repeat (7) begin
            tick();
            if (c_m_axis_tvalid !== 1'b0) early++;
        end
        retire_all();
        if (c_m_axis_tvalid !== 1'b0) early++;
        n_cmp++; if (early !== 0) begin
            n_fail++; $display("FAIL drain_early_send: got %0d tvalid cycles required 0", early);
        end
        capture_pkt(6, tmo, waited);
        n_cmp++; if (tmo !== 1'b0 || waited !== 2) begin
            n_fail++; $display("FAIL drain_send_latency: got %0d (timeout %b) required 2", waited, tmo);
        end
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL drain_len: got %0d beats required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL drain_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        n_cmp++; if ({c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tlast} !== '0) begin
            n_fail++; $display("FAIL drain_idle_zero: got %h required 0", c_m_axis_tdata);
        end
        n = 1;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        n_cmp++; if (n !== GUARD) begin
            n_fail++; $display("FAIL drain_guard_len: got %0d required %0d", n, GUARD);
        end
        n_cmp++; if ({c_s_axis_tready, phv_in_ready} !== 2'b11) begin
            n_fail++; $display("FAIL drain_reopen: got %b required 11", {c_s_axis_tready, phv_in_ready});
        end
    endtask

    task automatic test_simul_inc_dec();
        bit tmo;
        int waited;
        int early = 0;
        bit acc;
        push_phvs(1);
        phv_in = PW'($urandom);
        phv_in_valid = 1'b1;
        phv_retire = 1'b1;
        #1;
        acc = phv_out_valid && phv_out_ready;
        tick();
        model_step(acc, 1'b1);
        phv_in_valid = 1'b0;
        phv_retire = 1'b0;
        n_cmp++; if (acc !== 1'b1) begin
            n_fail++; $display("FAIL simul_accept: got %b required 1", acc);
        end
        send_pkt(1, 1'b1, tmo);
        repeat (10) begin
            tick();
            if (c_m_axis_tvalid !== 1'b0) early++;
        end
        n_cmp++; if (early !== 0) begin
            n_fail++; $display("FAIL simul_early_send: got %0d tvalid cycles required 0", early);
        end
        retire_all();
        capture_pkt(6, tmo, waited);
        n_cmp++; if (tmo !== 1'b0 || waited !== 2) begin
            n_fail++; $display("FAIL simul_send_latency: got %0d (timeout %b) required 2", waited, tmo);
        end
        n_cmp++; if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL simul_beat: got %0d beats, first %h required %h", obs_q.size(), obs_q.size() ? obs_q[0] : '0, exp_q[0]);
        end
        exp_q.delete();
        while (busy) tick();
    endtask

    task automatic test_oversize();
        bit tmo;
        int waited;
        int stray;
        int lens[2] = '{17, 20};
        n_cmp++; if (err_oversize !== 1'b0) begin
            n_fail++; $display("FAIL oversize_pre: got %b required 0", err_oversize);
        end
        foreach (lens[j]) begin
            send_pkt(lens[j], 1'b0, tmo);
            n_cmp++; if (tmo !== 1'b0) begin
                n_fail++; $display("FAIL oversize_tready_len%0d: got stall required accepted", lens[j]);
            end
            stray = 0;
            repeat (12) begin
                tick();
                if (c_m_axis_tvalid !== 1'b0 || busy !== 1'b0) stray++;
            end
            n_cmp++; if (err_oversize !== 1'b1 || stray !== 0) begin
                n_fail++; $display("FAIL oversize_len%0d: got err %b stray %0d required err 1 stray 0", lens[j], err_oversize, stray);
            end
        end
        send_pkt(1, 1'b1, tmo);
        capture_pkt(8, tmo, waited);
        n_cmp++; if (tmo !== 1'b0 || obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL oversize_followup: got %0d beats (timeout %b) required 1 matching beat", obs_q.size(), tmo);
        end
        exp_q.delete();
        while (busy) tick();
    endtask

    task automatic test_timeout();
        bit tmo;
        int waited;
        int n = 0;
        n_cmp++; if (err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL timeout_pre: got %b required 0", err_timeout);
        end
        push_phvs(1);
        send_pkt(2, 1'b1, tmo);
        while (!busy && n < 10) begin
            tick();
            n++;
        end
        n = 0;
        while (!err_timeout && n < 40) begin
            tick();
            n++;
        end
        n_cmp++; if (n < TMO - 1 || n > TMO + 1) begin
            n_fail++; $display("FAIL timeout_cycle: got %0d required %0d", n, TMO);
        end
        capture_pkt(4, tmo, waited);
        n_cmp++; if (tmo !== 1'b0 || obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL timeout_len: got %0d beats (timeout %b) required %0d", obs_q.size(), tmo, exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL timeout_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        while (busy) tick();
        retire_all();
        n_cmp++; if ({err_timeout, err_oversize} !== 2'b11) begin
            n_fail++; $display("FAIL errors_sticky: got %b required 11", {err_timeout, err_oversize});
        end
    endtask

    task automatic test_reset_mid_send();
        bit tmo;
        int waited;
        int n = 0;
        send_pkt(4, 1'b1, tmo);
        while (!c_m_axis_tvalid && n < 10) begin
            tick();
            n++;
        end
        n_cmp++; if ({c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tlast} !== exp_q[0] || c_m_axis_tvalid !== 1'b1) begin
            n_fail++; $display("FAIL midsend_beat0: got %b/%h required 1/%h", c_m_axis_tvalid, {c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tlast}, exp_q[0]);
        end
        tick();
        n_cmp++; if ({c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tlast} !== exp_q[1] || c_m_axis_tvalid !== 1'b1) begin
            n_fail++; $display("FAIL midsend_beat1: got %b/%h required 1/%h", c_m_axis_tvalid, {c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tlast}, exp_q[1]);
        end
        aresetn = 1'b0;
        tick();
        n_cmp++; if ({c_m_axis_tvalid, busy, c_s_axis_tready, err_timeout, err_oversize} !== 5'b0) begin
            n_fail++; $display("FAIL midsend_reset: got %b required 00000", {c_m_axis_tvalid, busy, c_s_axis_tready, err_timeout, err_oversize});
        end
        tick();
        aresetn = 1'b1;
        tick();
        exp_q.delete();
        infl_model = 0;
        n_cmp++; if (c_s_axis_tready !== 1'b1) begin
            n_fail++; $display("FAIL midsend_tready: got %b required 1", c_s_axis_tready);
        end
        send_pkt(1, 1'b1, tmo);
        capture_pkt(8, tmo, waited);
        n_cmp++; if (tmo !== 1'b0 || obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL midsend_fifo_empty: got %0d beats (timeout %b) required 1 matching beat", obs_q.size(), tmo);
        end
        exp_q.delete();
        while (busy) tick();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_drain();
        test_simul_inc_dec();
        test_oversize();
        test_timeout();
        test_reset_mid_send();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
